// File: rtl/flt_seq_ctrl_if.sv
// Configuration-source and FLT-side pins of the FLT sequencer, grouped as one bundle.
// Drivers are the source/bench (master); the sequencer uses the slave view.
interface flt_seq_ctrl_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int MEM_WIDTH  = 32
) ();
  logic                  Start_SI;
  logic                  ParValid_SI;
  logic [MEM_WIDTH-1:0]  ParData_DI;
  logic                  ParReady_SO;
  logic                  FltRst_RBO;
  logic                  WrEn_SO;
  logic [ADDR_WIDTH-1:0] Addr_DO;
  logic [MEM_WIDTH-1:0]  PAR_Out_DO;
  logic                  FltValid_SO;
  logic                  Busy_SO;
  logic                  Done_SO;

  modport master (
    output Start_SI, ParValid_SI, ParData_DI,
    input  ParReady_SO, FltRst_RBO, WrEn_SO, Addr_DO, PAR_Out_DO,
           FltValid_SO, Busy_SO, Done_SO
  );

  modport slave (
    input  Start_SI, ParValid_SI, ParData_DI,
    output ParReady_SO, FltRst_RBO, WrEn_SO, Addr_DO, PAR_Out_DO,
           FltValid_SO, Busy_SO, Done_SO
  );
endinterface

// File: rtl/flt_seq_ctrl.sv
// FLT sequencer: reset FLT, stream NUM_PAR parameter words into it, wait out warm-up, flag valid.
// Outputs are registered (one cycle after a handshake); ParReady is combinational and stalls are unbounded.
module flt_seq_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter int MEM_WIDTH  = 32,
  parameter int NUM_PAR    = 24,
  parameter int RST_CYC    = 2,
  parameter int WARMUP_CYC = 20,
  parameter int CNT_WIDTH  = 8
) (
  input  logic          Clk_CI,
  input  logic          Rst_RI,
  flt_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RST  = 3'd1,
    ST_LOAD = 3'd2,
    ST_WARM = 3'd3,
    ST_RUN  = 3'd4
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] RST_LAST  = CNT_WIDTH'(RST_CYC - 1);
  localparam logic [CNT_WIDTH-1:0] PAR_LAST  = CNT_WIDTH'(NUM_PAR - 1);
  localparam logic [CNT_WIDTH-1:0] WARM_LAST = CNT_WIDTH'(WARMUP_CYC - 1);

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  fltrst_q, fltrst_d;
  logic                  wren_q, wren_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [MEM_WIDTH-1:0]  data_q, data_d;
  logic                  fltvalid_q, fltvalid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  par_rdy;
  logic                  par_hs;

  assign par_rdy = (state_q == ST_LOAD);
  assign par_hs  = bus.ParValid_SI && par_rdy;

  // One counter serves all timed states: reset hold, word index and warm-up.
  always_comb begin : next_state
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.Start_SI) begin
          state_d = ST_RST;
          cnt_d   = '0;
        end
      end
      ST_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_LOAD: begin
        if (par_hs) begin
          if (cnt_q == PAR_LAST) begin
            state_d = ST_WARM;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      ST_WARM: begin
        if (cnt_q == WARM_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_RUN: begin
        if (bus.Start_SI) begin
          state_d = ST_RST;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Status outputs are decoded from the next state so they line up with the state register.
  always_comb begin : next_outputs
    fltrst_d   = (state_d == ST_LOAD) || (state_d == ST_WARM) || (state_d == ST_RUN);
    busy_d     = (state_d == ST_RST) || (state_d == ST_LOAD) || (state_d == ST_WARM);
    fltvalid_d = (state_d == ST_RUN);
    done_d     = (state_d == ST_RUN) && (state_q != ST_RUN);
    wren_d     = par_hs;
    addr_d     = addr_q;
    data_d     = data_q;
    if (par_hs) begin
      addr_d = ADDR_WIDTH'(cnt_q);
      data_d = bus.ParData_DI;
    end
  end

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      fltrst_q   <= 1'b0;
      wren_q     <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      fltvalid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fltrst_q   <= fltrst_d;
      wren_q     <= wren_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      fltvalid_q <= fltvalid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.ParReady_SO = par_rdy;
  assign bus.FltRst_RBO  = fltrst_q;
  assign bus.WrEn_SO     = wren_q;
  assign bus.Addr_DO     = addr_q;
  assign bus.PAR_Out_DO  = data_q;
  assign bus.FltValid_SO = fltvalid_q;
  assign bus.Busy_SO     = busy_q;
  assign bus.Done_SO     = done_q;

endmodule

// File: tb/tb_flt_seq_ctrl.sv
// Scoreboard bench for flt_seq_ctrl: stimulus derives expected writes, done pulses and per-cycle
// status from session timing; a negedge monitor pops and compares whatever the DUT presents.
module tb_flt_seq_ctrl;
  localparam int AW = 5;
  localparam int MW = 32;
  localparam int NP = 24;
  localparam int RC = 2;
  localparam int WC = 20;
  localparam int CW = 8;

  typedef struct {
    int          c;
    int          a;
    logic [31:0] d;
  } wr_t;

  typedef struct packed {
    logic rstb;
    logic busy;
    logic vld;
    logic rdy;
  } st_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  wr_t  wr_q[$];
  int   done_q[$];
  st_t  exp_st[int];
  wr_t  mw;
  int   md;

  flt_seq_ctrl_if #(.ADDR_WIDTH(AW), .MEM_WIDTH(MW)) bus ();

  flt_seq_ctrl #(
    .ADDR_WIDTH(AW), .MEM_WIDTH(MW), .NUM_PAR(NP),
    .RST_CYC(RC), .WARMUP_CYC(WC), .CNT_WIDTH(CW)
  ) dut (
    .Clk_CI(clk),
    .Rst_RI(rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic st_t mk(input logic a, input logic b, input logic c, input logic d);
    st_t s;
    s = {a, b, c, d};
    return s;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance n cycles, expecting a steady status in each.
  task automatic idle(input int n, input st_t s);
    for (int i = 0; i < n; i++) begin
      step();
      exp_st[cyc] = s;
    end
  endtask

  // Monitor: compare every presented write/done against the scoreboard, and status where predicted.
  always @(negedge clk) begin
    if (bus.WrEn_SO === 1'b1) begin
      if (wr_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL wr_unexpected: got write addr %0d data 0x%0h, want no write (cycle %0d)",
                 bus.Addr_DO, bus.PAR_Out_DO, cyc);
      end else begin
        mw = wr_q.pop_front();
        check("wr_cycle", 64'(cyc), 64'(mw.c));
        check("wr_addr", 64'(bus.Addr_DO), 64'(mw.a));
        check("wr_data", 64'(bus.PAR_Out_DO), 64'(mw.d));
      end
    end
    if (bus.Done_SO === 1'b1) begin
      if (done_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL done_unexpected: got Done_SO=1, want 0 (cycle %0d)", cyc);
      end else begin
        md = done_q.pop_front();
        check("done_cycle", 64'(cyc), 64'(md));
      end
    end
    if (exp_st.exists(cyc)) begin
      check("status{rstb,busy,vld,rdy}",
            64'({bus.FltRst_RBO, bus.Busy_SO, bus.FltValid_SO, bus.ParReady_SO}),
            64'(exp_st[cyc]));
      exp_st.delete(cyc);
    end
  end

  // mode 0: back-to-back, 1: valid every other cycle, 2: random stalls.
  // abort_at >= 0 asserts reset once that many words have been accepted.
  task automatic run_session(input int mode, input bit hold, input int abort_at, input bit ramp);
    int          t0;
    int          l0;
    int          k;
    int          lh;
    int          d;
    bit          v;
    logic [31:0] w;
    t0 = cyc;
    l0 = t0 + 1 + RC;
    bus.Start_SI = 1'b1;
    for (int c = t0 + 1; c < l0; c++) exp_st[c] = mk(1'b0, 1'b1, 1'b0, 1'b0);
    step();
    bus.Start_SI = hold;
    while (cyc < l0) step();
    k = 0;
    while (k < NP) begin
      if (abort_at >= 0 && k == abort_at) begin
        bus.ParValid_SI = 1'b0;
        rst = 1'b1;
        exp_st[cyc] = mk(1'b1, 1'b1, 1'b0, 1'b1);
        step();
        rst = 1'b0;
        bus.Start_SI = 1'b0;
        exp_st[cyc] = mk(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("abort_addr", 64'(bus.Addr_DO), 64'd0);
        check("abort_data", 64'(bus.PAR_Out_DO), 64'd0);
        return;
      end
      case (mode)
        0:       v = 1'b1;
        1:       v = ((cyc - l0) % 2) == 0;
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      w = ramp ? 32'(k) * 32'h0101_0101 : $urandom();
      bus.ParValid_SI = v;
      bus.ParData_DI  = v ? w : $urandom();
      exp_st[cyc] = mk(1'b1, 1'b1, 1'b0, 1'b1);
      if (v) begin
        wr_q.push_back('{c: cyc + 1, a: k, d: w});
        k++;
      end
      step();
    end
    bus.ParValid_SI = 1'b0;
    lh = cyc - 1;
    d  = lh + 1 + WC;
    done_q.push_back(d);
    for (int c = lh + 1; c < d; c++) exp_st[c] = mk(1'b1, 1'b1, 1'b0, 1'b0);
    exp_st[d] = mk(1'b1, 1'b0, 1'b1, 1'b0);
    while (cyc < d) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout at cycle %0d, want completion", cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.Start_SI    = 1'b0;
    bus.ParValid_SI = 1'b0;
    bus.ParData_DI  = '0;
    for (int c = 1; c <= 8; c++) exp_st[c] = mk(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) step();
    rst = 1'b0;
    while (cyc < 8) step();
    @(negedge clk);
    check("reset_addr", 64'(bus.Addr_DO), 64'd0);
    check("reset_data", 64'(bus.PAR_Out_DO), 64'd0);
    check("reset_done", 64'(bus.Done_SO), 64'd0);
    step();

    // Back-to-back ramp load, then sit in RUN.
    run_session(0, 1'b0, -1, 1'b1);
    bus.Start_SI = 1'b0;
    idle(3, mk(1'b1, 1'b0, 1'b1, 1'b0));

    // Reload from RUN with a source that stalls every other cycle.
    run_session(1, 1'b0, -1, 1'b0);
    bus.Start_SI = 1'b0;
    idle(2, mk(1'b1, 1'b0, 1'b1, 1'b0));

    // Reload, then reset after word 10; restart from IDLE must begin at address 0.
    run_session(2, 1'b0, 10, 1'b0);
    idle(4, mk(1'b0, 1'b0, 1'b0, 1'b0));
    run_session(2, 1'b0, -1, 1'b0);

    // Start held through the whole sequence: one done, then an immediate reload.
    run_session(2, 1'b1, -1, 1'b0);
    run_session(0, 1'b0, -1, 1'b0);
    bus.Start_SI = 1'b0;
    idle(3, mk(1'b1, 1'b0, 1'b1, 1'b0));
    repeat (2) step();

    check("writes_outstanding", 64'(wr_q.size()), 64'd0);
    check("dones_outstanding", 64'(done_q.size()), 64'd0);
    check("status_outstanding", 64'(exp_st.num()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
